layer_sched: RTL and testbench

LAYER_SCHED -- requirements
Module: layer_sched

---
 rtl/layer_sched.sv | 142 ++++++++++++++
 tb/tb_layer_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - layer scheduler: loads IFM/weight buffers, launches compute, signals done
// Optional macro LAYER_SCHED_WEIGHT_REUSE_EN adds reuse_w to skip weight reload on later layers.
module layer_sched #(
    parameter int ADDR_W    = 16,
    parameter int IFM_WORDS = 256,
    parameter int W_WORDS   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
    input  logic              reuse_w,
`endif
    input  logic              in_valid,
    input  logic [63:0]       in_data,
    output logic              in_ready,
    input  logic              ctl_ifm_ena,
    input  logic              ctl_w_ena,
    input  logic [ADDR_W-1:0] ctl_ifm_addr,
    input  logic [ADDR_W-1:0] ctl_w_addr,
    output logic              ifm_ena,
    output logic              weight_ena,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              wea,
    output logic [63:0]       buf_din,
    output logic              comp_start,
    input  logic              layer_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD_IFM, LOAD_W, COMPUTE, DONE} state_t;

    state_t            state, state_nxt;
    logic [15:0]       lcnt, lcnt_nxt;
    logic              first_q;
    logic              skip_w;
    logic [ADDR_W-1:0] lcnt_addr;

    assign lcnt_addr = ADDR_W'(lcnt);

`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
    logic reuse_q, done_seen;

    // Reuse only counts once a full layer has completed, so the first layer always loads weights.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reuse_q   <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            if (state == IDLE && go)
                reuse_q <= reuse_w && done_seen;
            if (state == DONE)
                done_seen <= 1'b1;
        end
    end
    assign skip_w = reuse_q;
`else
    assign skip_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lcnt    <= 16'd0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            lcnt    <= lcnt_nxt;
            first_q <= (state_nxt == COMPUTE) && (state != COMPUTE);
        end
    end

    always_comb begin
        state_nxt   = state;
        lcnt_nxt    = lcnt;
        in_ready    = 1'b0;
        ifm_ena     = 1'b0;
        weight_ena  = 1'b0;
        ifm_addr    = '0;
        weight_addr = '0;
        wea         = 1'b0;
        buf_din     = 64'd0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = LOAD_IFM;
                    lcnt_nxt  = 16'd0;
                end
            end
            LOAD_IFM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ifm_ena  = 1'b1;
                    wea      = 1'b1;
                    ifm_addr = lcnt_addr;
                    buf_din  = in_data;
                    if (lcnt == 16'(IFM_WORDS - 1)) begin
                        lcnt_nxt  = 16'd0;
                        state_nxt = skip_w ? COMPUTE : LOAD_W;
                    end else begin
                        lcnt_nxt = lcnt + 16'd1;
                    end
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    weight_ena  = 1'b1;
                    wea         = 1'b1;
                    weight_addr = lcnt_addr;
                    buf_din     = in_data;
                    if (lcnt == 16'(W_WORDS - 1)) begin
                        lcnt_nxt  = 16'd0;
                        state_nxt = COMPUTE;
                    end else begin
                        lcnt_nxt = lcnt + 16'd1;
                    end
                end
            end
            COMPUTE: begin
                ifm_ena     = ctl_ifm_ena;
                ifm_addr    = ctl_ifm_addr;
                weight_ena  = ctl_w_ena;
                weight_addr = ctl_w_addr;
                if (layer_ready)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign comp_start = first_q && (state == COMPUTE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - scoreboard bench for layer_sched (IFM_WORDS=4, W_WORDS=2)
module tb_layer_sched;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n, go, in_valid, in_ready;
    logic [63:0]       in_data, buf_din;
    logic              ctl_ifm_ena, ctl_w_ena;
    logic [ADDR_W-1:0] ctl_ifm_addr, ctl_w_addr, ifm_addr, weight_addr;
    logic              ifm_ena, weight_ena, wea, comp_start, layer_ready, busy, done;
`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
    logic              reuse_w;
`endif

    always #5 clk = ~clk;

    layer_sched #(.ADDR_W(ADDR_W), .IFM_WORDS(4), .W_WORDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
        .reuse_w(reuse_w),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ctl_ifm_ena(ctl_ifm_ena), .ctl_w_ena(ctl_w_ena),
        .ctl_ifm_addr(ctl_ifm_addr), .ctl_w_addr(ctl_w_addr),
        .ifm_ena(ifm_ena), .weight_ena(weight_ena),
        .ifm_addr(ifm_addr), .weight_addr(weight_addr),
        .wea(wea), .buf_din(buf_din), .comp_start(comp_start),
        .layer_ready(layer_ready), .busy(busy), .done(done)
    );

    // kind: 0 ifm write, 1 weight write, 2 comp_start, 3 done
    typedef struct {
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [ADDR_W-1:0] addr, input logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [ADDR_W-1:0] addr, input logic [63:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h required no event", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || addr !== e.addr || data !== e.data) begin
                n_fail++;
                $display("FAIL event: got kind=%0d addr=%0h data=%0h required kind=%0d addr=%0h data=%0h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (wea && ifm_ena)    observe(0, ifm_addr, buf_din);
        if (wea && weight_ena) observe(1, weight_addr, buf_din);
        if (comp_start)        observe(2, '0, 64'd0);
        if (done)              observe(3, '0, 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = 64'd0;
        ctl_ifm_ena = 1'b0; ctl_w_ena = 1'b0; ctl_ifm_addr = '0; ctl_w_addr = '0;
        layer_ready = 1'b0;
`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
        reuse_w = 1'b1;
`endif
        repeat (2) tick();
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_wea", wea, 0);
        check("reset_done", done, 0);
        check("reset_comp_start", comp_start, 0);
        check("reset_enables", {ifm_ena, weight_ena}, 0);
        check("reset_ifm_addr", ifm_addr, 0);
        check("reset_buf_din", buf_din, 0);

        // Layer 1: go on the first edge out of reset, continuous load
        rst_n = 1'b1; go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) push(0, ADDR_W'(i), 64'hA0 + 64'(i));
        for (int i = 0; i < 2; i++) push(1, ADDR_W'(i), 64'hA4 + 64'(i));
        push(2, '0, 64'd0);
        push(3, '0, 64'd0);
        @(negedge clk);
        check("load_busy", busy, 1);
        check("load_in_ready", in_ready, 1);
        load(6, 64'hA0);
        ctl_ifm_ena = 1'b1; ctl_ifm_addr = 16'h0012; go = 1'b1;
        @(negedge clk);
        check("compute_ifm_addr", ifm_addr, 16'h0012);
        check("compute_ifm_ena", ifm_ena, 1);
        check("compute_wea", wea, 0);
        check("compute_in_ready", in_ready, 0);
        check("compute_buf_din", buf_din, 0);
        tick();
        go = 1'b0;
        @(negedge clk);
        check("compute_start_once", comp_start, 0);
        check("compute_busy_after_go", busy, 1);
        layer_ready = 1'b1;
        tick();
        layer_ready = 1'b0; ctl_ifm_ena = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 1);
        tick();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Layer 2: stalled load then reset mid-load
        go = 1'b1;
        tick();
        go = 1'b0;
        push(0, 16'd0, 64'hB0);
        push(0, 16'd1, 64'hB2);
        push(0, 16'd2, 64'hC0);
        for (int i = 0; i < 4; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 64'hB0 + 64'(i);
            @(negedge clk);
            check("stall_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b1; in_data = 64'hC0;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_wea", wea, 0);
        check("midreset_busy", busy, 0);

        // Layer 3: first layer after reset loads weights; go with in_valid in IDLE writes nothing
        rst_n = 1'b1; go = 1'b1; in_valid = 1'b1; in_data = 64'hEE;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) push(0, ADDR_W'(i), 64'hD0 + 64'(i));
        for (int i = 0; i < 2; i++) push(1, ADDR_W'(i), 64'hD4 + 64'(i));
        push(2, '0, 64'd0);
        push(3, '0, 64'd0);
        load(4, 64'hD0);
        go = 1'b1;
        load(2, 64'hD4);
        go = 1'b0;
        layer_ready = 1'b1;
        tick();
        layer_ready = 1'b0;
        tick();
        @(negedge clk);
        check("layer3_idle_busy", busy, 0);

        // Layer 4: with reuse the weight load is skipped
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 4; i++) push(0, ADDR_W'(i), 64'hE0 + 64'(i));
`ifdef LAYER_SCHED_WEIGHT_REUSE_EN
        push(2, '0, 64'd0);
        push(3, '0, 64'd0);
        load(4, 64'hE0);
`else
        for (int i = 0; i < 2; i++) push(1, ADDR_W'(i), 64'hE4 + 64'(i));
        push(2, '0, 64'd0);
        push(3, '0, 64'd0);
        load(6, 64'hE0);
`endif
        ctl_w_ena = 1'b1; ctl_w_addr = 16'h0034;
        @(negedge clk);
        check("compute_weight_addr", weight_addr, 16'h0034);
        check("compute_weight_ena", weight_ena, 1);
        check("compute_busy", busy, 1);
        layer_ready = 1'b1;
        tick();
        layer_ready = 1'b0; ctl_w_ena = 1'b0;
        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
